dll_cfg_spi_slave: RTL and testbench

// SPI-style mode-0 serial responder that gives the off-chip host (driving the

---
 rtl/dll_cfg_spi_slave_if.sv | 10 +
 rtl/dll_cfg_spi_slave.sv | 108 ++++++++++
 tb/tb_dll_cfg_spi_slave.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dll_cfg_spi_slave_if.sv
// dll_cfg_spi_slave_if: host-facing serial pins of the DLL config responder
interface dll_cfg_spi_slave_if;
  logic sck;
  logic csn;
  logic sdi;
  logic sdo;
  logic sdo_oe;
  modport master (output sck, csn, sdi, input sdo, sdo_oe);
  modport slave (input sck, csn, sdi, output sdo, sdo_oe);
endinterface

// File: rtl/dll_cfg_spi_slave.sv
// dll_cfg_spi_slave: mode-0 serial responder giving the host R/W access to DLL config registers
module dll_cfg_spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 4,
  parameter int DATA_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  dll_cfg_spi_slave_if.slave         spi,
  input  logic [DATA_W-1:0]          status_in,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic                       wr_pulse,
  output logic [2:0]                 wr_addr,
  output logic                       frame_err
);
  localparam int CW = $clog2(DATA_W + 4);
  localparam int L = SYNC_STAGES - 1;
  localparam logic [3:0] NR = 4'(NUM_REGS);
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_s, csn_s, sdi_s;
  logic [SYNC_STAGES:0] vld;
  logic sck_d, csn_d;
  logic sck_rise, sck_fall, csn_rise, csn_fall, sdi_b, last, err, commit;
  logic [CW-1:0] cnt;
  logic [3:0] cmd_q;
  logic [DATA_W-1:0] wsh, rsh, wdata;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_tab [8];
  // vld marks when the csn pipeline holds real samples, so a csn already low at reset release is not a fall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sck_s <= '0;
      csn_s <= '1;
      sdi_s <= '0;
      sck_d <= 1'b0;
      csn_d <= 1'b1;
      vld   <= '0;
    end else begin
      sck_s <= {sck_s[SYNC_STAGES-2:0], spi.sck};
      csn_s <= {csn_s[SYNC_STAGES-2:0], spi.csn};
      sdi_s <= {sdi_s[SYNC_STAGES-2:0], spi.sdi};
      sck_d <= sck_s[L];
      csn_d <= csn_s[L];
      vld   <= {vld[SYNC_STAGES-1:0], 1'b1};
    end
  assign sck_rise = sck_s[L] & ~sck_d;
  assign sck_fall = ~sck_s[L] & sck_d;
  assign csn_fall = vld[SYNC_STAGES] & csn_d & ~csn_s[L];
  assign csn_rise = vld[SYNC_STAGES] & ~csn_d & csn_s[L];
  assign sdi_b = sdi_s[L];
  assign last = state_q == DATA && sck_rise && cnt == CW'(DATA_W - 1);
  assign wdata = {wsh[DATA_W-2:0], sdi_b};
  always_comb begin
    state_d = state_q;
    err = 1'b0;
    commit = 1'b0;
    case (state_q)
      IDLE: state_d = csn_fall ? CMD : IDLE;
      CMD: begin
        state_d = csn_rise ? IDLE : (sck_rise && cnt == CW'(3)) ? DATA : CMD;
        err = csn_rise;
      end
      DATA: begin
        state_d = last ? (csn_rise ? IDLE : DONE) : csn_rise ? IDLE : DATA;
        err = csn_rise && !last;
        commit = last && !cmd_q[3] && {1'b0, cmd_q[2:0]} < NR;
      end
      default: state_d = csn_rise ? IDLE : DONE;
    endcase
  end
  always_comb begin
    rd_tab = '{default: '0};
    rd_tab[7] = status_in;
    for (int i = 0; i < NUM_REGS; i++) rd_tab[i] = regs[i];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // the fall right after the 4th rise keeps the MSB on sdo; later falls advance the shifter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt       <= '0;
      cmd_q     <= '0;
      wsh       <= '0;
      rsh       <= '0;
      regs      <= '{default: '0};
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      cnt <= state_q != state_d ? '0 : sck_rise ? cnt + CW'(1) : cnt;
      if (state_q == CMD && sck_rise) cmd_q <= {cmd_q[2:0], sdi_b};
      if (state_q == CMD && sck_rise && cnt == CW'(3)) rsh <= rd_tab[{cmd_q[1:0], sdi_b}];
      else if (state_q == DATA && sck_fall && cnt != '0) rsh <= {rsh[DATA_W-2:0], 1'b0};
      if (state_q == DATA && sck_rise) wsh <= wdata;
      for (int i = 0; i < NUM_REGS; i++)
        if (commit && cmd_q[2:0] == 3'(i)) regs[i] <= wdata;
      wr_pulse  <= commit;
      wr_addr   <= commit ? cmd_q[2:0] : wr_addr;
      frame_err <= err;
    end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end
  assign spi.sdo_oe = state_q == DATA && cmd_q[3];
  assign spi.sdo = spi.sdo_oe & rsh[DATA_W-1];
endmodule

// File: tb/tb_dll_cfg_spi_slave.sv
// tb_dll_cfg_spi_slave: randomized frames against a register-array model with a queue scoreboard
module tb_dll_cfg_spi_slave;
  localparam int NR = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] status_in = 8'h00;
  logic [31:0] reg_q;
  logic wr_pulse, frame_err;
  logic [2:0] wr_addr;
  int tests = 0;
  int fails = 0;
  logic [7:0] model [NR];
  logic [10:0] exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rx_q[$];
  int exp_err = 0;
  logic [10:0] mon_e;
  dll_cfg_spi_slave_if spi();
  dll_cfg_spi_slave #(.SYNC_STAGES(2), .NUM_REGS(NR), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .spi(spi), .status_in(status_in), .reg_q(reg_q),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [31:0] model_flat();
    logic [31:0] f;
    for (int i = 0; i < NR; i++) f[i*8 +: 8] = model[i];
    return f;
  endfunction
  task automatic frame(input bit rw, input logic [2:0] a, input logic [7:0] d, input int nr,
                       input bit simul, output logic [7:0] rx, output bit oe_bad);
    logic [11:0] bits;
    bits = {rw, a, d};
    rx = 8'h00;
    oe_bad = 1'b0;
    spi.csn = 1'b0;
    clks(6);
    for (int i = 0; i < nr; i++) begin
      spi.sdi = bits[11-i];
      clks(6);
      if (i >= 4) rx = {rx[6:0], spi.sdo};
      if (spi.sdo_oe !== (rw && i >= 4)) oe_bad = 1'b1;
      spi.sck = 1'b1;
      if (simul && i == nr - 1) spi.csn = 1'b1;
      clks(6);
      spi.sck = 1'b0;
    end
    clks(6);
    spi.csn = 1'b1;
    clks(10);
  endtask
  task automatic xfer(input bit rw, input logic [2:0] a, input logic [7:0] d,
                      input int nr = 12, input bit simul = 1'b0);
    logic [7:0] rx;
    bit ob;
    bit full;
    full = nr == 12;
    if (full && !rw && a < NR) begin
      model[a] = d;
      exp_wr.push_back({a, d});
    end
    if (!full) exp_err++;
    if (full && rw) exp_rd.push_back(a == 7 ? status_in : a < NR ? model[a] : 8'h00);
    frame(rw, a, d, nr, simul, rx, ob);
    if (full && rw) rx_q.push_back(rx);
    chk("sdo_oe_window", 32'(ob), 0);
    chk("idle_sdo_oe_sdo", {30'd0, spi.sdo_oe, spi.sdo}, 0);
    chk("reg_q", reg_q, model_flat());
  endtask
  // scoreboard: every DUT strobe or received byte must match a queued expectation
  always @(negedge clk)
    if (!rst) begin
      if (wr_pulse) begin
        chk("wr_pulse_expected", 32'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(mon_e[10:8]));
          chk("wr_data", 32'(reg_q[mon_e[10:8]*8 +: 8]), 32'(mon_e[7:0]));
        end
      end
      if (frame_err) begin
        chk("frame_err_expected", 32'(exp_err > 0), 1);
        if (exp_err > 0) exp_err--;
      end
      if (rx_q.size() > 0) begin
        chk("rd_expected", 32'(exp_rd.size() > 0), 1);
        if (exp_rd.size() > 0) chk("rd_data", 32'(rx_q.pop_front()), 32'(exp_rd.pop_front()));
        else void'(rx_q.pop_front());
      end
    end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [11:0] bits;
    spi.sck = 1'b0;
    spi.csn = 1'b1;
    spi.sdi = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    clks(3);
    chk("rst_reg_q", reg_q, 0);
    chk("rst_strobes", {29'd0, wr_pulse, frame_err, spi.sdo_oe}, 0);
    chk("rst_wr_addr_sdo", {28'd0, wr_addr, spi.sdo}, 0);
    rst = 1'b0;
    clks(5);
    xfer(1'b0, 3'd1, 8'hA5);
    xfer(1'b1, 3'd1, 8'h00);
    status_in = 8'h3C;
    fork
      xfer(1'b1, 3'd7, 8'h00);
      begin clks(100); status_in = 8'hC3; end
    join
    xfer(1'b0, 3'd5, 8'hFF);
    xfer(1'b0, 3'd7, 8'hFF);
    xfer(1'b1, 3'd5, 8'h00);
    xfer(1'b0, 3'd2, 8'h5A, 7);
    xfer(1'b1, 3'd2, 8'h00, 2);
    xfer(1'b0, 3'd2, 8'h5A);
    xfer(1'b0, 3'd3, 8'h96, 12, 1'b1);
    xfer(1'b1, 3'd3, 8'h00);
    repeat (40) begin
      status_in = 8'($urandom);
      xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
    end
    spi.csn = 1'b0;
    clks(6);
    bits = 12'h0_FF;
    for (int i = 0; i < 3; i++) begin
      spi.sdi = bits[11-i];
      clks(6);
      spi.sck = 1'b1;
      clks(6);
      spi.sck = 1'b0;
    end
    #2 rst = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    clks(2);
    chk("midrst_reg_q", reg_q, 0);
    chk("midrst_outputs", {28'd0, wr_pulse, frame_err, spi.sdo_oe, spi.sdo}, 0);
    rst = 1'b0;
    clks(3);
    for (int i = 0; i < 12; i++) begin
      spi.sdi = bits[11-i];
      clks(6);
      spi.sck = 1'b1;
      clks(6);
      spi.sck = 1'b0;
    end
    clks(6);
    spi.csn = 1'b1;
    clks(10);
    chk("post_rst_ignored", reg_q, 0);
    xfer(1'b0, 3'd0, 8'h11);
    chk("post_rst_write", 32'(reg_q[7:0]), 32'h11);
    clks(20);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("rd_queue_drained", exp_rd.size() + rx_q.size(), 0);
    chk("err_queue_drained", exp_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
